// File: rtl/fp_unit_arbiter_pkg.sv
// Shared definitions for the FP unit arbiter: fpUnit opcodes, FSM encodings, literals.
// Latency: n/a (constants and a constant-folding helper only).
// Backpressure: n/a.
package fp_unit_arbiter_pkg;

  // fpUnit operation codes
  localparam logic [7:0] FP_SUB  = 8'd0;
  localparam logic [7:0] FP_ADD  = 8'd1;
  localparam logic [7:0] FP_DIV  = 8'd2;
  localparam logic [7:0] FP_MUL  = 8'd3;
  localparam logic [7:0] FP_FTOI = 8'd4;
  localparam logic [7:0] FP_ITOF = 8'd5;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // IEEE-754 single precision 1.0
  localparam logic [31:0] ONE_F = 32'h3F800000;

  // Watchdog counter width covers TIMEOUT up to 65535
  localparam int WD_W = 16;

  // Last WAIT count value before the watchdog fires
  function automatic logic [WD_W-1:0] wd_limit(input int timeout);
    return WD_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/fp_unit_arbiter_rr_priority_select.sv
// Rotating-priority encoder: first set req bit at or after rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects whether any request is present.
module rr_priority_select
  import fp_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IW-1:0]        w_ofs;
  logic [IW:0]          w_sum;

  // Rotate so that bit 0 of w_rot corresponds to requester rr_ptr
  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> rr_ptr;
  assign w_rot   = w_shift[NUM_REQ-1:0];
  assign valid   = |w_rot;

  // Lowest set bit of the rotated vector wins (scan high to low, last hit kept)
  always_comb begin
    w_ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_ofs = IW'(k);
    end
  end

  // Undo the rotation modulo NUM_REQ (works for non-power-of-two counts)
  assign w_sum = {1'b0, rr_ptr} + {1'b0, w_ofs};
  assign idx   = (w_sum >= NUM_REQ_W) ? IW'(w_sum - NUM_REQ_W) : w_sum[IW-1:0];

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin share of one fpUnit among NUM_REQ effect engines, with watchdog abort.
// Latency: req sampled at t -> fp_clk_en from t+1 -> fp_done at t+k -> req_done at t+k+1; issue period k+2.
// Backpressure: level req held by requester until req_done; one op in flight, others wait in IDLE arbitration.
module fp_unit_arbiter
  import fp_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int OP_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [32*NUM_REQ-1:0]       req_dataa,
  input  logic [32*NUM_REQ-1:0]       req_datab,
  input  logic [OP_WIDTH*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_err,
  output logic [31:0]                 result,
  output logic                        busy,
  output logic [31:0]                 fp_dataa,
  output logic [31:0]                 fp_datab,
  output logic [OP_WIDTH-1:0]         fp_operation,
  output logic                        fp_clk_en,
  input  logic                        fp_done,
  input  logic [31:0]                 fp_result
);

  localparam int               IW      = $clog2(NUM_REQ);
  localparam logic [WD_W-1:0]  WD_LAST = wd_limit(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONEHOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]          r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_idx;
  logic [WD_W-1:0]     r_wd_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_req_done;
  logic [NUM_REQ-1:0]  r_req_err;
  logic [31:0]         r_result;
  logic [31:0]         r_fp_dataa;
  logic [31:0]         r_fp_datab;
  logic [OP_WIDTH-1:0] r_fp_op;
  logic                r_fp_clk_en;

  logic                w_sel_vld;
  logic [IW-1:0]       w_sel_idx;
  logic [NUM_REQ-1:0]  w_sel_onehot;
  logic [NUM_REQ-1:0]  w_cur_onehot;
  logic [IW-1:0]       w_next_ptr;
  logic                w_timeout;
  logic [31:0]         w_a  [NUM_REQ];
  logic [31:0]         w_b  [NUM_REQ];
  logic [OP_WIDTH-1:0] w_op [NUM_REQ];

  // Split the flat requester buses into per-requester slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_a[g]  = req_dataa[32*g +: 32];
    assign w_b[g]  = req_datab[32*g +: 32];
    assign w_op[g] = req_op[OP_WIDTH*g +: OP_WIDTH];
  end

  rr_priority_select #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_sel_vld),
    .idx    (w_sel_idx)
  );

  assign w_sel_onehot = ONEHOT0 << w_sel_idx;
  assign w_cur_onehot = ONEHOT0 << r_idx;
  assign w_next_ptr   = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
  assign w_timeout    = (r_wd_cnt == WD_LAST);

  // Arbitration FSM; every output except busy comes straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_wd_cnt    <= '0;
      r_grant     <= '0;
      r_req_done  <= '0;
      r_req_err   <= '0;
      r_result    <= '0;
      r_fp_dataa  <= '0;
      r_fp_datab  <= '0;
      r_fp_op     <= '0;
      r_fp_clk_en <= 1'b0;
    end else begin
      r_req_done <= '0;
      r_req_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_vld) begin
            r_idx       <= w_sel_idx;
            r_fp_dataa  <= w_a[w_sel_idx];
            r_fp_datab  <= w_b[w_sel_idx];
            r_fp_op     <= w_op[w_sel_idx];
            r_grant     <= w_sel_onehot;
            r_fp_clk_en <= 1'b1;
            r_wd_cnt    <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // A completion on the watchdog's last cycle still counts as success
          if (fp_done) begin
            r_result    <= fp_result;
            r_fp_clk_en <= 1'b0;
            r_req_done  <= w_cur_onehot;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_result    <= '0;
            r_fp_clk_en <= 1'b0;
            r_req_done  <= w_cur_onehot;
            r_req_err   <= w_cur_onehot;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_grant  <= '0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign req_done     = r_req_done;
  assign req_err      = r_req_err;
  assign result       = r_result;
  assign busy         = (r_state != ST_IDLE);
  assign fp_dataa     = r_fp_dataa;
  assign fp_datab     = r_fp_datab;
  assign fp_operation = r_fp_op;
  assign fp_clk_en    = r_fp_clk_en;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Self-checking bench for fp_unit_arbiter: reset, vector table, directed arbitration, random traffic.
module tb_fp_unit_arbiter;
  import fp_unit_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int OW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_dataa;
  logic [32*N-1:0] req_datab;
  logic [OW*N-1:0] req_op;
  logic [N-1:0]    grant;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic [31:0]     result;
  logic            busy;
  logic [31:0]     fp_dataa;
  logic [31:0]     fp_datab;
  logic [OW-1:0]   fp_operation;
  logic            fp_clk_en;
  logic            fp_done;
  logic [31:0]     fp_result;

  always #5 clk = ~clk;

  fp_unit_arbiter #(
    .NUM_REQ  (N),
    .OP_WIDTH (OW),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dataa    (req_dataa),
    .req_datab    (req_datab),
    .req_op       (req_op),
    .grant        (grant),
    .req_done     (req_done),
    .req_err      (req_err),
    .result       (result),
    .busy         (busy),
    .fp_dataa     (fp_dataa),
    .fp_datab     (fp_datab),
    .fp_operation (fp_operation),
    .fp_clk_en    (fp_clk_en),
    .fp_done      (fp_done),
    .fp_result    (fp_result)
  );

  // fpUnit stand-in: done goes high 'lat' cycles after clk_en rises
  function automatic logic [31:0] fp_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == FP_ADD && a == ONE_F && b == 32'h40000000) return 32'h40400000;
    return (a + {b[15:0], b[31:16]}) ^ {24'h0, op};
  endfunction

  int lat = 1000;
  int stub_cnt = 0;
  always @(posedge clk) stub_cnt <= fp_clk_en ? stub_cnt + 1 : 0;
  assign fp_done   = fp_clk_en && (stub_cnt == lat);
  assign fp_result = fp_ref(fp_operation, fp_dataa, fp_datab);

  // Reference state: requester operands and the round-robin pointer
  logic [31:0] m_a  [N];
  logic [31:0] m_b  [N];
  logic [7:0]  m_op [N];
  int          m_ptr = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_dataa[32*i +: 32] = a;
    req_datab[32*i +: 32] = b;
    req_op[OW*i +: OW]    = op;
    m_a[i] = a; m_b[i] = b; m_op[i] = op;
  endtask

  // Round robin: first pending requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One transaction, started at a negedge while the arbiter is idle.
  // exp_cyc counts clock edges from the req-sampling edge to the edge that captures req_done.
  task automatic serve(input int exp_idx, input logic [31:0] exp_res, input logic exp_err,
                       input int exp_cyc, input bit keep);
    int cyc;
    bit seen;
    bit multi;
    cyc = 0; seen = 0; multi = 0;
    while (cyc < 200 && !seen) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if ($countones(grant) > 1) multi = 1;
      if (cyc == 1) begin
        chk("grant", {28'h0, grant}, 32'(1) << exp_idx);
        chk("fp_operation", {24'h0, fp_operation}, {24'h0, m_op[exp_idx]});
        chk("fp_dataa", fp_dataa, m_a[exp_idx]);
        chk("fp_datab", fp_datab, m_b[exp_idx]);
      end
      if (req_done != 0) seen = 1;
    end
    chk("done_seen", {31'h0, seen}, 32'd1);
    chk("req_done", {28'h0, req_done}, 32'(1) << exp_idx);
    chk("req_err", {28'h0, req_err}, exp_err ? (32'(1) << exp_idx) : 32'd0);
    chk("result", result, exp_res);
    chk("latency", cyc, exp_cyc);
    chk("clk_en_in_resp", {31'h0, fp_clk_en}, 32'd0);
    chk("grant_onehot", {31'h0, multi}, 32'd0);
    m_ptr = (exp_idx + 1) % N;
    if (keep) set_op(exp_idx, 8'($urandom_range(0, 5)), $urandom, $urandom);
    else req[exp_idx] = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {28'h0, req_done}, 32'd0);
    chk("idle_after_resp", {31'h0, busy}, 32'd0);
  endtask

  // Expectations from the reference model: done after lat+1 WAIT cycles unless the watchdog's TO cycles expire first
  task automatic model_serve(input bit keep);
    int i;
    bit e;
    int wait_cyc;
    logic [31:0] r;
    i = rr_pick(req, m_ptr);
    e = (lat + 1 > TO);
    wait_cyc = e ? TO : lat + 1;
    r = e ? 32'd0 : fp_ref(m_op[i], m_a[i], m_b[i]);
    serve(i, r, e, wait_cyc + 1, keep);
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vt [5];
  int   ord [6];
  int   ord2 [3];

  initial begin
    vt[0] = '{1, FP_ADD,  ONE_F,        32'h40000000, 5,    32'h40400000, 1'b0, 7};
    vt[1] = '{0, FP_MUL,  32'h12345678, 32'h9ABCDEF0, 1000, 32'h0,        1'b1, 17};
    vt[2] = '{3, FP_DIV,  32'h40800000, 32'h40000000, 15,   fp_ref(FP_DIV, 32'h40800000, 32'h40000000), 1'b0, 17};
    vt[3] = '{1, FP_ITOF, 32'h00000007, 32'h0,        0,    fp_ref(FP_ITOF, 32'h7, 32'h0), 1'b0, 2};
    vt[4] = '{2, FP_SUB,  32'hC0000000, ONE_F,        16,   32'h0,        1'b1, 17};
    ord  = '{0, 1, 2, 3, 0, 1};
    ord2 = '{2, 3, 2};

    rst = 1'b1;
    req = '0; req_dataa = '0; req_datab = '0; req_op = '0;
    for (int i = 0; i < N; i++) set_op(i, 8'h0, 32'h0, 32'h0);
    #1;
    chk("rst_grant", {28'h0, grant}, 32'd0);
    chk("rst_req_done", {28'h0, req_done}, 32'd0);
    chk("rst_req_err", {28'h0, req_err}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_fp_dataa", fp_dataa, 32'd0);
    chk("rst_fp_datab", fp_datab, 32'd0);
    chk("rst_fp_operation", {24'h0, fp_operation}, 32'd0);
    chk("rst_fp_clk_en", {31'h0, fp_clk_en}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;

    // All four requesting, each re-raised after service: strict rotation from 0
    for (int i = 0; i < N; i++) set_op(i, FP_MUL, 32'h1000 * (i + 1), 32'h40000000 + i);
    req = 4'b1111;
    lat = 3;
    for (int k = 0; k < 6; k++)
      serve(ord[k], fp_ref(m_op[ord[k]], m_a[ord[k]], m_b[ord[k]]), 1'b0, 5, 1'b1);

    // Requester 2 stays high after its done while 3 waits: 3 goes first, then 2 again
    req = 4'b1100;
    for (int k = 0; k < 3; k++)
      serve(ord2[k], fp_ref(m_op[ord2[k]], m_a[ord2[k]], m_b[ord2[k]]), 1'b0, 5, k == 0);

    // Vector table: single requesters, including the watchdog boundary cases
    for (int v = 0; v < 5; v++) begin
      set_op(vt[v].idx, vt[v].op, vt[v].a, vt[v].b);
      lat = vt[v].lat;
      req[vt[v].idx] = 1'b1;
      serve(vt[v].idx, vt[v].res, vt[v].err, vt[v].cyc, 1'b0);
    end

    // Reset during WAIT: outputs clear immediately, pointer restarts at 0
    set_op(2, FP_MUL, 32'h40400000, ONE_F);
    req = 4'b0100;
    lat = 1000;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_clk_en", {31'h0, fp_clk_en}, 32'd1);
    chk("pre_rst_grant", {28'h0, grant}, 32'd4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_clk_en", {31'h0, fp_clk_en}, 32'd0);
    chk("mid_rst_grant", {28'h0, grant}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    set_op(3, FP_FTOI, 32'h41200000, 32'h0);
    req = 4'b1100;
    lat = 4;
    model_serve(1'b0);
    model_serve(1'b0);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, 8'($urandom_range(0, 5)), $urandom, $urandom);
          req[i] = 1'b1;
        end
      if (req == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        set_op(j, 8'($urandom_range(0, 5)), $urandom, $urandom);
        req[j] = 1'b1;
      end
      lat = $urandom_range(0, 20);
      model_serve($urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
